// File: rtl/mem_line_engine.sv
// Line mover: fill = one burst read, flush = back-to-back single writes; done pulses one cycle after the last word, cmd_ready low while busy.
// Stalls on mem_waitrequest indefinitely unless MEM_LINE_TIMEOUT_EN adds a 16-bit no-progress watchdog that aborts with a sticky error.
module mem_line_engine #(
    parameter int         burst_bits = 2,
    parameter logic [1:0] my_id      = 2'd1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic                  cmd_write,
    input  logic [29:0]           cmd_address,
    output logic                  cmd_ready,
    output logic                  done,
    output logic                  error,
    input  logic [burst_bits-1:0] buf_addr,
    input  logic                  buf_we,
    input  logic [31:0]           buf_wdata,
    output logic [31:0]           buf_rdata,
    input  logic                  mem_waitrequest,
    output logic [1:0]            mem_id,
    output logic [29:0]           mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [31:0]           mem_writedata,
    output logic [3:0]            mem_writedatamask,
    input  logic [31:0]           mem_readdata,
    input  logic [1:0]            mem_readdataid
);
    localparam int              BL   = 1 << burst_bits;
    localparam logic [burst_bits:0] LAST = (burst_bits + 1)'(BL - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, FINISH} state_t;

    state_t                state_q, state_d;
    logic [29:0]           base_q, base_d;
    logic [burst_bits:0]   cnt_q, cnt_d;
    logic [31:0]           buf_q [BL];
    logic                  buf_wen;
    logic [burst_bits-1:0] buf_widx;
    logic [31:0]           buf_wval;
    logic                  word_hit;
    logic                  last_word;
    logic [burst_bits-1:0] idx;

    assign word_hit  = (mem_readdataid == my_id);
    assign last_word = (cnt_q == LAST);
    assign idx       = cnt_q[burst_bits-1:0];

`ifdef MEM_LINE_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;
    logic        error_q, error_d;
    logic        progress;

    // Any accepted request or captured word counts as forward progress.
    assign progress = ((state_q == RD_REQ)  && !mem_waitrequest) ||
                      ((state_q == RD_DATA) && word_hit) ||
                      ((state_q == WR_REQ)  && !mem_waitrequest);
`endif

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        buf_wen  = 1'b0;
        buf_widx = buf_addr;
        buf_wval = buf_wdata;
`ifdef MEM_LINE_TIMEOUT_EN
        error_d  = error_q;
        wdog_d   = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                buf_wen = buf_we;
                if (cmd_valid) begin
                    base_d  = cmd_address & ~30'(BL - 1);
                    cnt_d   = '0;
                    state_d = cmd_write ? WR_REQ : RD_REQ;
`ifdef MEM_LINE_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                end
            end
            RD_REQ, RD_DATA: begin
                if ((state_q == RD_REQ) && !mem_waitrequest)
                    state_d = RD_DATA;
                // A zero-latency slave may return the first word in the accept cycle.
                if (word_hit && ((state_q == RD_DATA) || !mem_waitrequest)) begin
                    buf_wen  = 1'b1;
                    buf_widx = idx;
                    buf_wval = mem_readdata;
                    cnt_d    = cnt_q + 1'b1;
                    if (last_word)
                        state_d = FINISH;
                end
            end
            WR_REQ: begin
                if (!mem_waitrequest) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_word)
                        state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef MEM_LINE_TIMEOUT_EN
        if ((state_q == RD_REQ) || (state_q == RD_DATA) || (state_q == WR_REQ)) begin
            if (progress) begin
                wdog_d = '0;
            end else if (wdog_q == 16'hFFFF) begin
                wdog_d  = '0;
                error_d = 1'b1;
                state_d = FINISH;
            end else begin
                wdog_d = wdog_q + 16'd1;
            end
        end else begin
            wdog_d = '0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
`ifdef MEM_LINE_TIMEOUT_EN
            wdog_q  <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
`ifdef MEM_LINE_TIMEOUT_EN
            wdog_q  <= wdog_d;
            error_q <= error_d;
`endif
        end
    end

    // Line storage is deliberately left unreset.
    always_ff @(posedge clock) begin
        if (buf_wen)
            buf_q[buf_widx] <= buf_wval;
    end

    assign cmd_ready         = (state_q == IDLE);
    assign done              = (state_q == FINISH);
    assign mem_read          = (state_q == RD_REQ);
    assign mem_write         = (state_q == WR_REQ);
    assign mem_id            = my_id;
    assign mem_writedatamask = 4'hF;
    assign mem_address       = mem_read  ? base_q :
                               mem_write ? (base_q + 30'(cnt_q)) : '0;
    assign mem_writedata     = mem_write ? buf_q[idx] : '0;
    assign buf_rdata         = buf_q[buf_addr];
`ifdef MEM_LINE_TIMEOUT_EN
    assign error             = error_q;
`else
    assign error             = 1'b0;
`endif
endmodule

// File: tb/tb_mem_line_engine.sv
// Directed bench for mem_line_engine: scripted slave, queues of expected requests and buffer words checked as they appear.
module tb_mem_line_engine;
    logic        clock = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_write;
    logic [29:0] cmd_address;
    logic        cmd_ready, done, error;
    logic [1:0]  buf_addr;
    logic        buf_we;
    logic [31:0] buf_wdata, buf_rdata;
    logic        mem_waitrequest;
    logic [1:0]  mem_id;
    logic [29:0] mem_address;
    logic        mem_read, mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;
    logic [31:0] mem_readdata;
    logic [1:0]  mem_readdataid;

    int n_assert = 0;
    int n_fail   = 0;

    logic [29:0] rd_q [$];
    logic [61:0] wr_q [$];
    logic [31:0] buf_exp [$];
    logic [29:0] exp_ra;
    logic [61:0] exp_wr;
    logic [1:0]  t2_id [9];

    always #5 clock = ~clock;

    mem_line_engine #(.burst_bits(2), .my_id(2'd1)) dut (
        .clock(clock), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_address(cmd_address),
        .cmd_ready(cmd_ready), .done(done), .error(error),
        .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .mem_waitrequest(mem_waitrequest), .mem_id(mem_id), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_writedatamask(mem_writedatamask), .mem_readdata(mem_readdata),
        .mem_readdataid(mem_readdataid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check_buf(input string tag);
        for (int i = 0; i < 4; i++) begin
            buf_addr = 2'(i);
            #1;
            chk(tag, buf_rdata, buf_exp.pop_front());
        end
    endtask

    // Bus monitor: every accepted request must match the next expected one.
    always @(negedge clock) begin
        if (mem_read || mem_write)
            chk("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
        if (mem_read && !mem_waitrequest) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_read", 32'd1, 32'd0);
            end else begin
                exp_ra = rd_q.pop_front();
                chk("rd_addr", 32'(mem_address), 32'(exp_ra));
            end
        end
        if (mem_write && !mem_waitrequest) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                exp_wr = wr_q.pop_front();
                chk("wr_addr", 32'(mem_address), 32'(exp_wr[61:32]));
                chk("wr_data", mem_writedata, exp_wr[31:0]);
                chk("wr_mask", 32'(mem_writedatamask), 32'hF);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation did not complete, n_assert=%0d", n_assert);
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
        buf_addr = '0; buf_we = 1'b0; buf_wdata = '0;
        mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdataid = '0;
        t2_id = '{2'd2, 2'd1, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd1};
        cyc(); cyc();

        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_writedata", mem_writedata, 32'd0);
        chk("rst_mask", 32'(mem_writedatamask), 32'hF);
        chk("rst_mem_id", 32'(mem_id), 32'd1);
        rst = 1'b0;
        cyc();

        // Fill, zero-wait slave, first word returned in the accept cycle.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 30'h100;
        rd_q.push_back(30'h100);
        cyc();
        cmd_valid = 1'b0;
        chk("t1_cmd_ready_drop", 32'(cmd_ready), 32'd0);
        chk("t1_mem_read", 32'(mem_read), 32'd1);
        chk("t1_mem_address", 32'(mem_address), 32'h100);
        for (int i = 0; i < 4; i++) begin
            mem_readdataid = 2'd1;
            mem_readdata   = 32'hA0 + 32'(i);
            buf_exp.push_back(32'hA0 + 32'(i));
            cyc();
            if (i == 0) chk("t1_read_single", 32'(mem_read), 32'd0);
            if (i < 3)  chk("t1_no_early_done", 32'(done), 32'd0);
        end
        mem_readdataid = 2'd0;
        chk("t1_done", 32'(done), 32'd1);
        cyc();
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_ready_back", 32'(cmd_ready), 32'd1);
        check_buf("t1_buf");

        // Fill with request stall and foreign/empty id cycles interleaved.
        cmd_valid = 1'b1; cmd_address = 30'h100; mem_waitrequest = 1'b1;
        rd_q.push_back(30'h100);
        cyc();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t2_stall_read", 32'(mem_read), 32'd1);
            chk("t2_stall_addr", 32'(mem_address), 32'h100);
            cyc();
        end
        mem_waitrequest = 1'b0;
        chk("t2_addr_at_accept", 32'(mem_address), 32'h100);
        cyc();
        begin
            int n = 0;
            for (int j = 0; j < 9; j++) begin
                mem_readdataid = t2_id[j];
                if (t2_id[j] == 2'd1) begin
                    mem_readdata = 32'hB0 + 32'(n);
                    buf_exp.push_back(32'hB0 + 32'(n));
                    n++;
                end else begin
                    mem_readdata = 32'hBAD00 + 32'(j);
                end
                cyc();
                if (j < 8) chk("t2_no_early_done", 32'(done), 32'd0);
            end
        end
        mem_readdataid = 2'd0;
        chk("t2_done", 32'(done), 32'd1);
        cyc();
        check_buf("t2_buf");

        // Flush at unaligned 0x203 with a stall on word 2.
        for (int i = 0; i < 4; i++) begin
            buf_addr  = 2'(i);
            buf_wdata = 32'(17 * (i + 1));
            buf_we    = 1'b1;
            wr_q.push_back({30'(30'h200 + 30'(i)), 32'(17 * (i + 1))});
            cyc();
        end
        buf_we = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 30'h203;
        cyc();
        cmd_valid = 1'b0;
        chk("t3_write", 32'(mem_write), 32'd1);
        chk("t3_addr0", 32'(mem_address), 32'h200);
        chk("t3_data0", mem_writedata, 32'h11);
        cyc(); cyc();
        mem_waitrequest = 1'b1;
        chk("t3_addr2", 32'(mem_address), 32'h202);
        chk("t3_data2", mem_writedata, 32'h33);
        cyc();
        chk("t3_stall_write", 32'(mem_write), 32'd1);
        chk("t3_stall_addr2", 32'(mem_address), 32'h202);
        chk("t3_stall_data2", mem_writedata, 32'h33);
        mem_waitrequest = 1'b0;
        cyc();
        chk("t3_addr3", 32'(mem_address), 32'h203);
        cyc();
        chk("t3_write_drop", 32'(mem_write), 32'd0);
        chk("t3_done", 32'(done), 32'd1);
        cyc();
        chk("t3_ready_back", 32'(cmd_ready), 32'd1);

        // Client writes during a fill are ignored; a held command waits for done.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 30'h300;
        rd_q.push_back(30'h300);
        cyc();
        buf_we = 1'b1; buf_addr = 2'd0; buf_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            mem_readdataid = 2'd1;
            mem_readdata   = 32'hC0 + 32'(i);
            buf_exp.push_back(32'hC0 + 32'(i));
            cyc();
            chk("t4_ready_busy", 32'(cmd_ready), 32'd0);
            if (i == 1) chk("t4_partial_fill", buf_rdata, 32'hC0);
        end
        buf_we = 1'b0; mem_readdataid = 2'd0;
        chk("t4_done", 32'(done), 32'd1);
        rd_q.push_back(30'h300);
        cyc();
        chk("t4_ready_after_done", 32'(cmd_ready), 32'd1);
        chk("t4_done_pulse", 32'(done), 32'd0);
        check_buf("t4_buf_unchanged");
        cyc();
        cmd_valid = 1'b0;
        chk("t4_held_accepted", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            mem_readdataid = 2'd1;
            mem_readdata   = 32'hD0 + 32'(i);
            buf_exp.push_back(32'hD0 + 32'(i));
            cyc();
        end
        mem_readdataid = 2'd0;
        chk("t4_done2", 32'(done), 32'd1);
        cyc();
        check_buf("t4_buf2");

        // Reset in RD_DATA after two words.
        cmd_valid = 1'b1; cmd_address = 30'h400;
        rd_q.push_back(30'h400);
        cyc();
        cmd_valid = 1'b0;
        cyc();
        mem_readdataid = 2'd1; mem_readdata = 32'hE0;
        cyc();
        mem_readdata = 32'hE1;
        cyc();
        mem_readdataid = 2'd0;
        rst = 1'b1;
        cyc();
        chk("t5_read_drop", 32'(mem_read), 32'd0);
        chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_error", 32'(error), 32'd0);
        rst = 1'b0;
        cyc();

`ifdef MEM_LINE_TIMEOUT_EN
        begin
            int n = 0;
            mem_waitrequest = 1'b1;
            cmd_valid = 1'b1; cmd_address = 30'h500;
            cyc();
            cmd_valid = 1'b0;
            while (!done && n < 70000) begin
                cyc();
                n++;
            end
            chk("to_done", 32'(done), 32'd1);
            chk("to_cycle_window", 32'(n >= 65535 && n <= 65537), 32'd1);
            chk("to_error_set", 32'(error), 32'd1);
            cyc();
            chk("to_done_pulse", 32'(done), 32'd0);
            chk("to_error_sticky", 32'(error), 32'd1);
            mem_waitrequest = 1'b0;
            cmd_valid = 1'b1; cmd_address = 30'h100;
            rd_q.push_back(30'h100);
            cyc();
            cmd_valid = 1'b0;
            chk("to_error_cleared", 32'(error), 32'd0);
            for (int i = 0; i < 4; i++) begin
                mem_readdataid = 2'd1;
                mem_readdata   = 32'hF0 + 32'(i);
                buf_exp.push_back(32'hF0 + 32'(i));
                cyc();
            end
            mem_readdataid = 2'd0;
            chk("to_refill_done", 32'(done), 32'd1);
            cyc();
            check_buf("to_buf");
        end
`endif

        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
